// File: rtl/dm_cache_ctrl_param.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl_param
//
// Parametrised direct-mapped, write-back / write-allocate cache controller
// sitting between a core data port and a word-wide memory model. Lines hold
// WORDS_PER_LINE words. Misses are serviced by a burst of memory beats. A dirty
// victim line is first written back beat by beat, then the new line is
// refilled beat by beat.
//
// Optional feature macro: DM_CACHE_STATS_EN
//   When defined, adds three saturating 32-bit counters on output ports
//   hit_count, miss_count and wb_count.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_req_addr        byte address of the CPU request
//   cpu_req_data        CPU write data
//   cpu_req_rw          0 = read, 1 = write
//   cpu_req_valid       CPU request valid (accepted only in IDLE)
//   cpu_res_data        read data, or the written data for writes
//   cpu_res_ready       one-cycle response pulse
//   cpu_res_checked     1 = request hit on its first tag compare
//   cpu_res_index       line index that serviced the request
//   mem_req_addr        word-aligned beat address
//   mem_req_data        write-back beat data
//   mem_req_rw          0 = read beat, 1 = write beat
//   mem_req_valid       beat request, held until mem_res_ready is seen
//   mem_res_data        read beat data
//   mem_res_ready       beat complete
//   hit_count, miss_count, wb_count   (DM_CACHE_STATS_EN only)
// -----------------------------------------------------------------------------
module dm_cache_ctrl_param #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int INDEX_W        = 7,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W-1:0]   cpu_req_data,
    input  logic                cpu_req_rw,
    input  logic                cpu_req_valid,
    output logic [DATA_W-1:0]   cpu_res_data,
    output logic                cpu_res_ready,
    output logic                cpu_res_checked,
    output logic [INDEX_W-1:0]  cpu_res_index,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_data,
    output logic                mem_req_rw,
    output logic                mem_req_valid,
    input  logic [DATA_W-1:0]   mem_res_data,
    input  logic                mem_res_ready
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
    output logic [31:0]         wb_count
`endif
);

    // Address field geometry
    localparam int BO      = $clog2(DATA_W / 8);
    localparam int WO      = $clog2(WORDS_PER_LINE);
    localparam int TAG_LSB = BO + WO + INDEX_W;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam int LINES   = 1 << INDEX_W;
    localparam int DA_W    = INDEX_W + WO;          // {index, word} into the data array
    localparam int DEPTH   = LINES * WORDS_PER_LINE;
    localparam int BEAT_W  = WO + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITE_BACK,
        S_ALLOCATE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured request
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rw;
    logic               r_refilled;     // a refill happened for the current request

    logic [BEAT_W-1:0]  r_beat;

    // Line state; valid/dirty are reset, tag/data arrays are not
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [TAG_W-1:0]   r_tag_mem  [0:LINES-1];
    logic [DATA_W-1:0]  r_data_mem [0:DEPTH-1];

    // Registered CPU response
    logic [DATA_W-1:0]  r_cpu_res_data;
    logic               r_cpu_res_ready;
    logic               r_cpu_res_checked;
    logic [INDEX_W-1:0] r_cpu_res_index;

    // Decoded fields of the captured request
    logic [TAG_W-1:0]   w_req_tag;
    logic [INDEX_W-1:0] w_index;
    logic [DA_W-1:0]    w_word_addr;
    logic [DA_W-1:0]    w_beat_addr;
    logic [TAG_W-1:0]   w_line_tag;
    logic [TAG_W-1:0]   w_mem_tag;
    logic               w_hit;
    logic               w_last_beat;
    logic               w_beat_done;

    assign w_req_tag   = TAG_W'(r_addr >> TAG_LSB);
    assign w_index     = INDEX_W'(r_addr >> (BO + WO));
    // Dropping the byte offset leaves {tag, index, word}; truncation keeps {index, word}
    assign w_word_addr = DA_W'(r_addr >> BO);
    assign w_beat_addr = (DA_W'(w_index) << WO) | DA_W'(r_beat);
    assign w_line_tag  = r_tag_mem[w_index];
    assign w_hit       = r_valid[w_index] && (w_line_tag == w_req_tag);
    assign w_last_beat = (r_beat == BEAT_W'(WORDS_PER_LINE - 1));
    assign w_beat_done = mem_req_valid && mem_res_ready;

    // Write-back beats address the victim line, refill beats the requested line
    assign w_mem_tag   = (r_state == S_WRITE_BACK) ? w_line_tag : w_req_tag;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and memory request outputs. The memory side is decoded from
    // state so that an asynchronous reset drops mem_req_valid at once.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    w_state_next = S_IDLE;
                end else if (r_valid[w_index] && r_dirty[w_index]) begin
                    w_state_next = S_WRITE_BACK;
                end else begin
                    w_state_next = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = (ADDR_W'(w_mem_tag) << TAG_LSB)
                              | (ADDR_W'(w_index) << (BO + WO))
                              | (ADDR_W'(r_beat) << BO);
                mem_req_data  = r_data_mem[w_beat_addr];
                if (mem_res_ready && w_last_beat) begin
                    w_state_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = (ADDR_W'(w_mem_tag) << TAG_LSB)
                              | (ADDR_W'(w_index) << (BO + WO))
                              | (ADDR_W'(r_beat) << BO);
                if (mem_res_ready && w_last_beat) begin
                    w_state_next = S_COMPARE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers: request capture, beat counter, valid/dirty, response
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr            <= '0;
            r_wdata           <= '0;
            r_rw              <= 1'b0;
            r_refilled        <= 1'b0;
            r_beat            <= '0;
            r_valid           <= '0;
            r_dirty           <= '0;
            r_cpu_res_data    <= '0;
            r_cpu_res_ready   <= 1'b0;
            r_cpu_res_checked <= 1'b0;
            r_cpu_res_index   <= '0;
        end else begin
            r_cpu_res_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_addr     <= cpu_req_addr;
                        r_wdata    <= cpu_req_data;
                        r_rw       <= cpu_req_rw;
                        r_refilled <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (w_hit) begin
                        r_cpu_res_ready   <= 1'b1;
                        r_cpu_res_index   <= w_index;
                        r_cpu_res_checked <= !r_refilled;
                        if (r_rw) begin
                            r_cpu_res_data   <= r_wdata;
                            r_dirty[w_index] <= 1'b1;
                        end else begin
                            r_cpu_res_data <= r_data_mem[w_word_addr];
                        end
                    end else begin
                        r_beat     <= '0;
                        r_refilled <= 1'b1;
                    end
                end
                S_WRITE_BACK: begin
                    if (w_beat_done) begin
                        if (w_last_beat) begin
                            r_beat           <= '0;
                            r_dirty[w_index] <= 1'b0;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (w_beat_done) begin
                        if (w_last_beat) begin
                            r_beat           <= '0;
                            r_valid[w_index] <= 1'b1;
                            r_dirty[w_index] <= 1'b0;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                    r_beat <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Tag and data arrays (no reset). A write hit updates the word in COMPARE;
    // refill beats land in ALLOCATE, and the tag is written with the last beat.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == S_COMPARE && w_hit && r_rw) begin
            r_data_mem[w_word_addr] <= r_wdata;
        end
        if (r_state == S_ALLOCATE && mem_res_ready) begin
            r_data_mem[w_beat_addr] <= mem_res_data;
            if (w_last_beat) begin
                r_tag_mem[w_index] <= w_req_tag;
            end
        end
    end

    assign cpu_res_data    = r_cpu_res_data;
    assign cpu_res_ready   = r_cpu_res_ready;
    assign cpu_res_checked = r_cpu_res_checked;
    assign cpu_res_index   = r_cpu_res_index;

`ifdef DM_CACHE_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: [0] first-compare hits, [1] first-compare misses,
    // [2] completed line write-backs. Counters saturate at all-ones.
    // -------------------------------------------------------------------------
    logic [2:0]       w_stat_inc;
    logic [2:0][31:0] w_stat_cnt;

    // A miss can only occur on the first compare: after a refill the line hits
    assign w_stat_inc[0] = (r_state == S_COMPARE) && w_hit && !r_refilled;
    assign w_stat_inc[1] = (r_state == S_COMPARE) && !w_hit;
    assign w_stat_inc[2] = (r_state == S_WRITE_BACK) && mem_res_ready && w_last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stat
            logic [31:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_stat_inc[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign w_stat_cnt[gi] = r_cnt;
        end
    endgenerate

    assign hit_count  = w_stat_cnt[0];
    assign miss_count = w_stat_cnt[1];
    assign wb_count   = w_stat_cnt[2];
`endif

endmodule

// File: doc/dm_cache_ctrl_param.md
Name: dm_cache_ctrl_param

Overview:
Parametrised direct-mapped write-back/write-allocate cache controller. It sits between the core's data port and the memory model, and generalises the fixed 32-bit, 128-block, single-word-line cache types to configurable address width, depth and multi-word lines. It adds burst refill and dirty-line write-back over the memory interface, and reports the cache index used for each response.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width; power of two, minimum 8
INDEX_W, 7, index bits; 2**INDEX_W lines
WORDS_PER_LINE, 4, words per line; power of two, minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  reset
cpu_req_addr  in  ADDR_W  byte address
cpu_req_data  in  DATA_W  write data
cpu_req_rw  in  1  0=read, 1=write
cpu_req_valid  in  1  request valid
cpu_res_data  out  DATA_W  read data
cpu_res_ready  out  1  one-cycle response pulse
cpu_res_checked  out  1  response was a first-compare hit
cpu_res_index  out  INDEX_W  line index serviced
mem_req_addr  out  ADDR_W  word-aligned beat address
mem_req_data  out  DATA_W  write-back data
mem_req_rw  out  1  0=read, 1=write
mem_req_valid  out  1  beat request
mem_res_data  in  DATA_W  read beat data
mem_res_ready  in  1  beat complete

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All outputs reset to 0. State resets to IDLE. All valid and dirty bits clear. The data and tag arrays have no reset.
- Address split: BO=log2(DATA_W/8) and WO=log2(WORDS_PER_LINE).
  - word = addr[BO+WO-1:BO]
  - index = addr[BO+WO+INDEX_W-1:BO+WO]
  - tag = the remaining upper bits
- Request acceptance: a request is accepted only in IDLE when cpu_req_valid=1. Address, data and rw are captured into registers, and the FSM moves to COMPARE.
- CPU handshake: the CPU holds the request until cpu_res_ready, then drops valid the cycle after. Valid still high in IDLE counts as a new request. Requests in any other state are ignored.
- FSM states: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- COMPARE, hit (valid && tag match):
  - Pulse cpu_res_ready for one cycle, with cpu_res_index driven.
  - Read: cpu_res_data = the addressed word.
  - Write: update the word, set dirty; cpu_res_data = the written data.
  - cpu_res_checked = 1 if no refill occurred for this request, else 0.
  - Next state IDLE. Hit latency is 1 cycle after acceptance.
- COMPARE, miss: go to WRITE_BACK if the line is valid and dirty, otherwise to ALLOCATE. The beat counter clears.
- WRITE_BACK:
  - Issue WORDS_PER_LINE write beats at {old_tag, index, beat, BO zeros} with mem_req_rw=1, in ascending beat order.
  - After the last beat: clear dirty, go to ALLOCATE.
- ALLOCATE:
  - Issue read beats at {new_tag, index, beat, BO zeros}, and write mem_res_data into the line word on each completion.
  - After the last beat: set valid, clear dirty, write the tag, return to COMPARE. The request now hits, with checked=0.
- Memory handshake:
  - mem_req_valid is held high with stable addr, data and rw until a rising edge sees mem_res_ready=1. The beat then completes and the counter increments.
  - Valid stays high into the next beat without a gap.
  - Valid falls in the cycle after the final beat.
  - mem_res_ready while valid=0 is ignored.
- Wrap and boundaries:
  - The beat counter is WO+1 bits, and the last beat is detected at WORDS_PER_LINE-1.
  - WORDS_PER_LINE=1 gives single-beat transfers.
  - The index wraps naturally: the top address decodes to the last line.
- Reset mid-operation: the transfer is abandoned and mem_req_valid drops immediately (asynchronously). The partially filled line stays invalid.

Optional Feature:
Macro: DM_CACHE_STATS_EN.
- Defined: adds three outputs (hit_count, miss_count and wb_count, each 32 bits), all saturating at 0xFFFFFFFF and reset to 0.
  - hit_count increments once per request when its first COMPARE hits.
  - miss_count increments once per request when its first COMPARE misses.
  - wb_count increments once per completed line write-back.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
Test configuration: INDEX_W=6, WORDS_PER_LINE=4, DATA_W=32, so index is addr[9:4].
1. After reset, read 0x0000_0040, memory returning 0xA0..0xA3 -> 4 read beats at 0x40/0x44/0x48/0x4C, then ready with data=0xA0, checked=0, index=4.
2. Read 0x0000_0044 -> ready one cycle after acceptance with data=0xA1, checked=1, and no mem_req_valid.
3. Write 0xDEADBEEF to 0x48, then read 0x448 -> 4 write beats at 0x40..0x4C with 0x48 carrying 0xDEADBEEF, then 4 read beats at 0x440..0x44C, then ready with checked=0.
4. Hold mem_res_ready low 5 cycles on beat 2 -> mem_req_addr, mem_req_data and mem_req_valid stable throughout; beat completes on the first ready edge.
5. Assert rst_n=0 during ALLOCATE beat 1 -> all outputs 0 immediately; a subsequent read of the same address misses with a full 4-beat refill.
6. With DM_CACHE_STATS_EN, run scenarios 1-3 -> hit_count=2, miss_count=2, wb_count=1.
